dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and an off-chip line-wide memory.
- Replaces the MEM stage's direct data-memory access.
- Hits complete in the request cycle with no stall.
- Misses hold cpu_stall_o high, which freezes the whole pipeline, while the FSM writes back a dirty victim and refills the line.

---
 rtl/dcache_controller_pkg.sv | 19 +
 rtl/dcache_sram.sv | 66 ++++++
 rtl/dcache_controller.sv | 147 ++++++++++++++
 tb/tb_dcache_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared constants and types for the direct-mapped write-back L1 data cache.
package dcache_controller_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_REFILL    = 2'd2;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;

    typedef struct packed {
        logic              req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
    } mem_cmd_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one read port, a full-line
// fill port, a single-word merge port and a dirty-clear port.
module dcache_sram
    import dcache_controller_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int LINE_W   = 256,
    parameter int TAG_W    = 23
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$clog2(NUM_SETS)-1:0]     rd_idx,
    input  logic [WORD_SEL_W-1:0]           rd_sel,
    output logic                            rd_valid,
    output logic                            rd_dirty,
    output logic [TAG_W-1:0]                rd_tag,
    output logic [LINE_W-1:0]               rd_line,
    output logic [WORD_W-1:0]               rd_word,
    input  logic                            fill_we,
    input  logic [$clog2(NUM_SETS)-1:0]     fill_idx,
    input  logic [TAG_W-1:0]                fill_tag,
    input  logic [LINE_W-1:0]               fill_line,
    input  logic                            merge_we,
    input  logic [$clog2(NUM_SETS)-1:0]     merge_idx,
    input  logic [WORD_SEL_W-1:0]           merge_sel,
    input  logic [WORD_W-1:0]               merge_word,
    input  logic                            clean_we,
    input  logic [$clog2(NUM_SETS)-1:0]     clean_idx
);
    localparam int LINE_WORDS = LINE_W / WORD_W;

    logic [NUM_SETS-1:0]                                valid_q;
    logic [NUM_SETS-1:0]                                dirty_q;
    logic [NUM_SETS-1:0][TAG_W-1:0]                     tag_q;
    logic [NUM_SETS-1:0][LINE_WORDS-1:0][WORD_W-1:0]    data_q;

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
                dirty_q[fill_idx] <= 1'b0;
            end
            if (clean_we) dirty_q[clean_idx] <= 1'b0;
            if (merge_we) dirty_q[merge_idx] <= 1'b1;
        end
    end

    // Tags and line data are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end
        if (merge_we) data_q[merge_idx][merge_sel] <= merge_word;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int LINE_W   = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_wr_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:OFFSET_W] miss_line_q;
    logic [TAG_W-1:0]         cpu_tag, miss_tag, rd_tag;
    logic [INDEX_W-1:0]       cpu_idx, miss_idx, rd_idx;
    logic [WORD_SEL_W-1:0]    cpu_word;
    logic                     rd_valid, rd_dirty;
    logic [LINE_W-1:0]        rd_line;
    logic [WORD_W-1:0]        rd_word;
    logic                     idle, in_wb, in_refill, hit, fill_we, clean_we, merge_we;
    logic                     addr_unused;
    mem_cmd_t                 mem_cmd;

    assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_idx     = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_word    = cpu_addr_i[2 +: WORD_SEL_W];
    assign addr_unused = ^cpu_addr_i[1:0];
    assign miss_tag    = miss_line_q[ADDR_W-1 -: TAG_W];
    assign miss_idx    = miss_line_q[OFFSET_W +: INDEX_W];

    assign idle      = (state_q == ST_IDLE);
    assign in_wb     = (state_q == ST_WRITEBACK);
    assign in_refill = (state_q == ST_REFILL);

    // Outside IDLE the array is addressed by the latched miss line so the
    // victim stays visible on the memory bus even if the CPU drops its request.
    assign rd_idx   = idle ? cpu_idx : miss_idx;
    assign hit      = cpu_req_i && rd_valid && (rd_tag == cpu_tag);
    assign fill_we  = in_refill && mem_ack_i;
    assign clean_we = in_wb && mem_ack_i;
    assign merge_we = idle && hit && cpu_wr_i;

    assign cpu_stall_o = (cpu_req_i && !hit) || !idle;
    assign cpu_data_o  = (idle && hit && !cpu_wr_i) ? rd_word : '0;

    always_comb begin
        mem_cmd = '0;
        if (in_wb) begin
            mem_cmd.req  = 1'b1;
            mem_cmd.wr   = 1'b1;
            mem_cmd.addr = {rd_tag, miss_idx, {OFFSET_W{1'b0}}};
        end else if (in_refill) begin
            mem_cmd.req  = 1'b1;
            mem_cmd.addr = {miss_line_q, {OFFSET_W{1'b0}}};
        end
    end

    assign mem_req_o  = mem_cmd.req;
    assign mem_wr_o   = mem_cmd.wr;
    assign mem_addr_o = mem_cmd.addr;
    assign mem_data_o = in_wb ? rd_line : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (cpu_req_i && !hit)
                              state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
            ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
            ST_REFILL:    if (mem_ack_i) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            miss_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (idle && cpu_req_i && !hit) miss_line_q <= cpu_addr_i[ADDR_W-1:OFFSET_W];
        end
    end

    dcache_sram #(
        .NUM_SETS (NUM_SETS),
        .LINE_W   (LINE_W),
        .TAG_W    (TAG_W)
    ) u_sram (
        .clk        (clk_i),
        .rst        (rst_i),
        .rd_idx     (rd_idx),
        .rd_sel     (cpu_word),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .rd_word    (rd_word),
        .fill_we    (fill_we),
        .fill_idx   (miss_idx),
        .fill_tag   (miss_tag),
        .fill_line  (mem_data_i),
        .merge_we   (merge_we),
        .merge_idx  (cpu_idx),
        .merge_sel  (cpu_word),
        .merge_word (cpu_data_i),
        .clean_we   (clean_we),
        .clean_idx  (miss_idx)
    );

`ifdef DCACHE_STATS_EN
    // The hit in the cycle right after a refill completes a miss, not a new hit.
    logic refill_ret_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
            refill_ret_q <= 1'b0;
        end else begin
            refill_ret_q <= fill_we;
            if (idle && hit && !refill_ret_q) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (idle && (state_d != ST_IDLE)) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a line-wide memory model of
// programmable latency.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req, mem_wr, mem_ack = 1'b0;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wline, mem_rline = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    int n_chk = 0, n_fail = 0;
    int mem_lat = 10, mem_cnt = 0, wb_cnt = 0;
    logic [31:0]  wb_addr = '0, rf_addr = '0;
    logic [255:0] wb_line = '0;
    logic [255:0] mem_line [32];

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_wr_i    (cpu_wr),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_wr_o    (mem_wr),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wline),
        .mem_data_i  (mem_rline),
        .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory answers after the request has been up for mem_lat cycles.
    initial begin
        for (int i = 0; i < 32; i++)
            for (int w = 0; w < 8; w++)
                mem_line[i][w*32 +: 32] = {16'hA5A5, 16'(i*32 + w*4)};
        mem_line[2][2*32 +: 32] = 32'h0000_1234;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end else begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_ack = 1'b1;
                    mem_cnt = 0;
                    if (mem_wr) begin
                        mem_line[mem_addr[9:5]] = mem_wline;
                        wb_cnt++;
                        wb_addr = mem_addr;
                        wb_line = mem_wline;
                    end else begin
                        mem_rline = mem_line[mem_addr[9:5]];
                        rf_addr   = mem_addr;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
    end

    // One CPU access: returns the number of stalled cycles and the load data
    // seen in the completing cycle.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        stalls = 0;
        #1;
        while (cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_wr = 1'b0;
    endtask

    int          st, wb0;
    logic [31:0] rd;

    initial begin
        #3;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mreq", mem_req, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_rdata", cpu_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        // cold clean miss, then hits in the same line
        access(0, 32'h40, 0, st, rd);
        chk("cold_stall", st, 11);
        chk("cold_raddr", rf_addr, 32'h40);
        chk("cold_data", rd, 32'hA5A5_0040);
        access(0, 32'h48, 0, st, rd);
        chk("hit48_stall", st, 0);
        chk("hit48_data", rd, 32'h1234);

        // write hit, then read it back
        access(1, 32'h44, 32'hDEAD_BEEF, st, rd);
        chk("wrhit_stall", st, 0);
        access(0, 32'h44, 0, st, rd);
        chk("rdback_stall", st, 0);
        chk("rdback_data", rd, 32'hDEAD_BEEF);

        // conflicting read evicts the dirty line
        wb0 = wb_cnt;
        access(0, 32'h244, 0, st, rd);
        chk("dirty_stall", st, 21);
        chk("dirty_wbcnt", wb_cnt - wb0, 1);
        chk("dirty_wbaddr", wb_addr, 32'h40);
        chk("dirty_wbw1", wb_line[63:32], 32'hDEAD_BEEF);
        chk("dirty_wbw2", wb_line[95:64], 32'h1234);
        chk("dirty_raddr", rf_addr, 32'h240);
        chk("dirty_data", rd, 32'hA5A5_0244);

        // write miss allocates, merges, and is later written back
        wb0 = wb_cnt;
        access(1, 32'hA0, 32'h5, st, rd);
        chk("wrmiss_stall", st, 11);
        chk("wrmiss_nowb", wb_cnt - wb0, 0);
        access(0, 32'hA0, 0, st, rd);
        chk("wrmiss_rd", rd, 32'h5);
        access(0, 32'h2A0, 0, st, rd);
        chk("a0_evict_stall", st, 21);
        chk("a0_wbaddr", wb_addr, 32'hA0);
        chk("a0_wbw0", wb_line[31:0], 32'h5);
        chk("a0_data", rd, 32'hA5A5_02A0);

        // evicted data reaches memory and comes back
        access(0, 32'h40, 0, st, rd);
        chk("reload_stall", st, 11);
        access(0, 32'h44, 0, st, rd);
        chk("reload_w1", rd, 32'hDEAD_BEEF);

        // minimum latency
        mem_lat = 1;
        access(0, 32'h60, 0, st, rd);
        chk("lat1_stall", st, 2);
        chk("lat1_data", rd, 32'hA5A5_0060);
        mem_lat = 10;

        // store request dropped mid-miss: line fills, store is not done
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'hC0; cpu_wdata = 32'h77;
        repeat (2) @(negedge clk);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        for (int i = 0; i < 50 && mem_req; i++) @(negedge clk);
        chk("drop_mreq_done", mem_req, 0);
        access(0, 32'hC0, 0, st, rd);
        chk("drop_stall", st, 0);
        chk("drop_data", rd, 32'hA5A5_00C0);

        // reset in the middle of a refill
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h80;
        repeat (3) @(negedge clk);
        chk("pre_rst_mreq", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mreq", mem_req, 0);
        chk("midrst_maddr", mem_addr, 0);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // after reset everything misses again; stats sequence miss/hit/hit/dirty miss
        access(0, 32'h48, 0, st, rd);
        chk("post_rst_stall", st, 11);
        chk("post_rst_data", rd, 32'h1234);
        access(1, 32'h44, 32'hCAFE_F00D, st, rd);
        chk("post_wr_stall", st, 0);
        access(0, 32'h44, 0, st, rd);
        chk("post_rd_data", rd, 32'hCAFE_F00D);
        access(0, 32'h244, 0, st, rd);
        chk("post_dirty_stall", st, 21);
        chk("post_wbw1", wb_line[63:32], 32'hCAFE_F00D);
`ifdef DCACHE_STATS_EN
        #1;
        chk("stat_hits", hit_cnt, 2);
        chk("stat_misses", miss_cnt, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
